// File: rtl/ysyx_22041071_mem_arbiter_pkg.sv
// Shared encodings and bus widths for the instruction/data memory arbiter.
// Widths match those used by the downstream AXI bridge.
package ysyx_22041071_mem_arbiter_pkg;

    localparam int unsigned ADDR_BUS            = 64;
    localparam int unsigned DATA_BUS            = 64;
    localparam int unsigned AXI_LEN_WIDTH       = 8;
    localparam int unsigned AXI_RESP_TYPE_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IF  = 2'd1,
        RD_MEM = 2'd2,
        WR_MEM = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/ysyx_22041071_mem_arbiter_grant.sv
// Grant selection between fetch and data masters.
// YSYX_22041071_ARB_RR_EN selects round-robin; otherwise data always wins.
module ysyx_22041071_arb_grant
    import ysyx_22041071_mem_arbiter_pkg::*;
(
`ifdef YSYX_22041071_ARB_RR_EN
    input  logic clk,
    input  logic reset_n,
`endif
    input  logic arb_en,
    input  logic if_req,
    input  logic mem_req,
    output logic grant_if,
    output logic grant_mem
);

    logic mem_wins;

`ifdef YSYX_22041071_ARB_RR_EN
    owner_t last_grant;

    // On contention the master that did not win last time gets the bus.
    assign mem_wins = mem_req && (!if_req || (last_grant == OWN_IF));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWN_IF;
        end else if (grant_if || grant_mem) begin
            last_grant <= grant_mem ? OWN_MEM : OWN_IF;
        end
    end
`else
    assign mem_wins = mem_req;
`endif

    assign grant_mem = arb_en && mem_wins;
    assign grant_if  = arb_en && if_req && !mem_wins;

endmodule

// File: rtl/ysyx_22041071_mem_arbiter.sv
// Two-master arbiter (fetch read-only, data read/write) in front of the AXI bridge.
// Build option: YSYX_22041071_ARB_RR_EN enables round-robin arbitration.
module ysyx_22041071_mem_arbiter
    import ysyx_22041071_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_BUS,
    parameter int unsigned DATA_W = DATA_BUS,
    parameter int unsigned LEN_W  = AXI_LEN_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           if_req_valid,
    input  logic [ADDR_W-1:0]              if_addr,
    input  logic [LEN_W-1:0]               if_len,
    input  logic [1:0]                     if_size,
    output logic                           if_req_ready,
    output logic                           if_r_valid,
    output logic [DATA_W-1:0]              if_r_data,
    output logic [AXI_RESP_TYPE_WIDTH-1:0] if_resp,
    input  logic                           mem_req_valid,
    input  logic                           mem_we,
    input  logic [ADDR_W-1:0]              mem_addr,
    input  logic [LEN_W-1:0]               mem_len,
    input  logic [1:0]                     mem_size,
    input  logic [DATA_W-1:0]              mem_wdata,
    output logic                           mem_req_ready,
    output logic                           mem_r_valid,
    output logic [DATA_W-1:0]              mem_r_data,
    output logic [AXI_RESP_TYPE_WIDTH-1:0] mem_resp,
    output logic                           mem_w_done,
    output logic                           bus_ar_valid,
    output logic                           bus_aw_valid,
    output logic [ADDR_W-1:0]              bus_addr,
    output logic [LEN_W-1:0]               bus_len,
    output logic [1:0]                     bus_size,
    output logic [DATA_W-1:0]              bus_data,
    input  logic                           bus_ar_ready,
    input  logic                           bus_r_valid,
    input  logic [DATA_W-1:0]              bus_r_data,
    input  logic [AXI_RESP_TYPE_WIDTH-1:0] bus_resp,
    input  logic                           bus_aw_ready
);

    arb_state_t       state;
    logic [LEN_W-1:0] beat_cnt;
    logic             grant_if;
    logic             grant_mem;

    ysyx_22041071_arb_grant u_grant (
`ifdef YSYX_22041071_ARB_RR_EN
        .clk       (clk),
        .reset_n   (reset_n),
`endif
        .arb_en    (state == IDLE),
        .if_req    (if_req_valid),
        .mem_req   (mem_req_valid),
        .grant_if  (grant_if),
        .grant_mem (grant_mem)
    );

    assign if_req_ready  = grant_if;
    assign mem_req_ready = grant_mem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            bus_ar_valid <= 1'b0;
            bus_aw_valid <= 1'b0;
            bus_addr     <= '0;
            bus_len      <= '0;
            bus_size     <= '0;
            bus_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        bus_addr <= mem_addr;
                        bus_size <= mem_size;
                        beat_cnt <= '0;
                        if (mem_we) begin
                            state        <= WR_MEM;
                            bus_aw_valid <= 1'b1;
                            bus_len      <= '0;
                            bus_data     <= mem_wdata;
                        end else begin
                            state        <= RD_MEM;
                            bus_ar_valid <= 1'b1;
                            bus_len      <= mem_len;
                            bus_data     <= '0;
                        end
                    end else if (grant_if) begin
                        state        <= RD_IF;
                        bus_ar_valid <= 1'b1;
                        bus_addr     <= if_addr;
                        bus_len      <= if_len;
                        bus_size     <= if_size;
                        bus_data     <= '0;
                        beat_cnt     <= '0;
                    end
                end
                RD_IF, RD_MEM: begin
                    if (bus_ar_valid && bus_ar_ready) begin
                        bus_ar_valid <= 1'b0;
                    end
                    // Beats may precede the address handshake; they still count.
                    if (bus_r_valid) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt == bus_len) begin
                            state        <= IDLE;
                            bus_ar_valid <= 1'b0;
                        end
                    end
                end
                WR_MEM: begin
                    if (bus_aw_ready) begin
                        bus_aw_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_r_valid  = (state == RD_IF) && bus_r_valid;
    assign if_r_data   = if_r_valid ? bus_r_data : '0;
    assign if_resp     = if_r_valid ? bus_resp : '0;

    assign mem_r_valid = (state == RD_MEM) && bus_r_valid;
    assign mem_r_data  = mem_r_valid ? bus_r_data : '0;
    assign mem_w_done  = (state == WR_MEM) && bus_aw_ready;
    assign mem_resp    = (mem_r_valid || mem_w_done) ? bus_resp : '0;

endmodule

// File: tb/tb_ysyx_22041071_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: random masters, bridge stub, queue-based checking.
// Honours YSYX_22041071_ARB_RR_EN the same way as the design.
module tb_ysyx_22041071_mem_arbiter;

    localparam int EV_GRANT = 0;
    localparam int EV_BEAT  = 1;
    localparam int EV_WDONE = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req_valid, if_req_ready, if_r_valid;
    logic [63:0] if_addr, if_r_data;
    logic [7:0]  if_len;
    logic [1:0]  if_size, if_resp;
    logic        mem_req_valid, mem_we, mem_req_ready, mem_r_valid, mem_w_done;
    logic [63:0] mem_addr, mem_wdata, mem_r_data;
    logic [7:0]  mem_len;
    logic [1:0]  mem_size, mem_resp;
    logic        bus_ar_valid, bus_aw_valid, bus_ar_ready, bus_r_valid, bus_aw_ready;
    logic [63:0] bus_addr, bus_data, bus_r_data;
    logic [7:0]  bus_len;
    logic [1:0]  bus_size, bus_resp;

    typedef struct { int kind; bit owner; logic [63:0] data; logic [1:0] resp; } ev_t;
    typedef struct { bit wr; logic [63:0] addr; logic [7:0] len; logic [1:0] size; logic [63:0] data; } bq_t;

    ev_t exp_q[$];
    bq_t bus_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  manual_bus = 1'b0;
`ifdef YSYX_22041071_ARB_RR_EN
    bit  last_grant_m = 1'b0;   // 0 = fetch, 1 = data
`endif

    always #5 clk = ~clk;

    ysyx_22041071_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LEN_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_addr(if_addr), .if_len(if_len), .if_size(if_size),
        .if_req_ready(if_req_ready), .if_r_valid(if_r_valid), .if_r_data(if_r_data), .if_resp(if_resp),
        .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_req_ready(mem_req_ready),
        .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_resp(mem_resp), .mem_w_done(mem_w_done),
        .bus_ar_valid(bus_ar_valid), .bus_aw_valid(bus_aw_valid), .bus_addr(bus_addr), .bus_len(bus_len),
        .bus_size(bus_size), .bus_data(bus_data), .bus_ar_ready(bus_ar_ready), .bus_r_valid(bus_r_valid),
        .bus_r_data(bus_r_data), .bus_resp(bus_resp), .bus_aw_ready(bus_aw_ready)
    );

    // Bridge-stub content: read data and responses are pure functions of address and beat.
    function automatic logic [63:0] data_fn(logic [63:0] a, int b);
        return (a * 64'd3) ^ (64'(b) * 64'h9E37_79B9_7F4A_7C15);
    endfunction

    function automatic logic [1:0] resp_fn(logic [63:0] a, int b);
        return (((int'(a[11:4]) + b) % 5) == 3) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] wresp_fn(logic [63:0] a);
        return a[4] ? 2'b10 : 2'b00;
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    task automatic fail_now(string n);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one transaction's full expected trace in master-visible order.
    task automatic model_txn(bit is_mem, bit wr, logic [63:0] a, logic [7:0] l, logic [1:0] s, logic [63:0] wd);
        bq_t bq;
        exp_q.push_back('{EV_GRANT, is_mem, 64'd0, 2'b00});
        if (wr) begin
            exp_q.push_back('{EV_WDONE, 1'b1, 64'd0, wresp_fn(a)});
            bq = '{1'b1, a, 8'd0, s, wd};
        end else begin
            for (int b = 0; b <= int'(l); b++)
                exp_q.push_back('{EV_BEAT, is_mem, data_fn(a, b), resp_fn(a, b)});
            bq = '{1'b0, a, l, s, 64'd0};
        end
        bus_q.push_back(bq);
    endtask

    task automatic pop_cmp(int kind, bit owner, logic [63:0] d, logic [1:0] r, string n);
        ev_t e;
        if (exp_q.size() == 0) begin
            fail_now({"unexpected_", n});
        end else begin
            e = exp_q.pop_front();
            chk({n, "_kind"}, 64'(kind), 64'(e.kind));
            chk({n, "_owner"}, 64'(owner), 64'(e.owner));
            if (kind == EV_BEAT) chk({n, "_data"}, d, e.data);
            if (kind != EV_GRANT) chk({n, "_resp"}, 64'(r), 64'(e.resp));
        end
    endtask

    // Monitor: compare every master-visible event against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (if_req_ready || mem_req_ready) begin
                if (if_req_ready && mem_req_ready) chk("dual_grant", 64'(if_req_ready & mem_req_ready), 64'd0);
                pop_cmp(EV_GRANT, mem_req_ready, 64'd0, 2'b00, "grant");
            end
            if (if_r_valid)  pop_cmp(EV_BEAT, 1'b0, if_r_data, if_resp, "if_beat");
            if (mem_r_valid) pop_cmp(EV_BEAT, 1'b1, mem_r_data, mem_resp, "mem_beat");
            if (mem_w_done)  pop_cmp(EV_WDONE, 1'b1, 64'd0, mem_resp, "wdone");
            if (bus_ar_valid || bus_aw_valid)
                chk("ar_aw_exclusive", 64'(bus_ar_valid & bus_aw_valid), 64'd0);
        end
    end

    // Bridge stub: checks the latched request, then answers with handshake and beats.
    initial begin : bus_model
        logic [63:0] a;
        logic [7:0]  l;
        int          b0;
        bq_t         bq;
        bus_ar_ready = 1'b0; bus_aw_ready = 1'b0; bus_r_valid = 1'b0;
        bus_r_data = '0; bus_resp = '0;
        forever begin
            tick();
            if (!manual_bus && reset_n && (bus_ar_valid || bus_aw_valid)) begin
                a = bus_addr;
                l = bus_len;
                if (bus_q.size() == 0) begin
                    fail_now("unexpected_bus_req");
                end else begin
                    bq = bus_q.pop_front();
                    chk("bus_is_write", 64'(bus_aw_valid), 64'(bq.wr));
                    chk("bus_addr", bus_addr, bq.addr);
                    chk("bus_len", 64'(bus_len), 64'(bq.len));
                    chk("bus_size", 64'(bus_size), 64'(bq.size));
                    if (bq.wr) chk("bus_data", bus_data, bq.data);
                end
                if (bus_aw_valid) begin
                    repeat ($urandom_range(0, 2)) tick();
                    bus_aw_ready = 1'b1; bus_resp = wresp_fn(a);
                    tick();
                    bus_aw_ready = 1'b0; bus_resp = '0;
                end else begin
                    b0 = 0;
                    if (l != 8'd0 && $urandom_range(0, 3) == 0) begin
                        bus_r_valid = 1'b1; bus_r_data = data_fn(a, 0); bus_resp = resp_fn(a, 0);
                        tick();
                        bus_r_valid = 1'b0; bus_resp = '0;
                        b0 = 1;
                    end
                    repeat ($urandom_range(0, 2)) tick();
                    bus_ar_ready = 1'b1;
                    tick();
                    bus_ar_ready = 1'b0;
                    for (int b = b0; b <= int'(l); b++) begin
                        repeat ($urandom_range(0, 1)) tick();
                        bus_r_valid = 1'b1; bus_r_data = data_fn(a, b); bus_resp = resp_fn(a, b);
                        tick();
                        bus_r_valid = 1'b0; bus_resp = '0;
                    end
                end
            end
        end
    end

    task automatic run_round(bit ui, bit um, logic [63:0] ia, logic [7:0] il, logic [1:0] isz,
                             bit we, logic [63:0] ma, logic [7:0] ml, logic [1:0] msz, logic [63:0] md);
        bit mem_first;
        bit gi, gm;
        int cnt;
        if_addr = ia; if_len = il; if_size = isz;
        mem_we = we; mem_addr = ma; mem_len = ml; mem_size = msz; mem_wdata = md;
        mem_first = 1'b1;
`ifdef YSYX_22041071_ARB_RR_EN
        mem_first = (last_grant_m == 1'b0);
        if (ui && um) last_grant_m = mem_first ? 1'b0 : 1'b1;
        else if (um)  last_grant_m = 1'b1;
        else if (ui)  last_grant_m = 1'b0;
`endif
        if (ui && um && !mem_first) begin
            model_txn(1'b0, 1'b0, ia, il, isz, 64'd0);
            model_txn(1'b1, we, ma, ml, msz, md);
        end else begin
            if (um) model_txn(1'b1, we, ma, ml, msz, md);
            if (ui) model_txn(1'b0, 1'b0, ia, il, isz, 64'd0);
        end
        if_req_valid = ui;
        mem_req_valid = um;
        cnt = 0;
        while ((if_req_valid || mem_req_valid) && cnt < 4000) begin
            @(negedge clk);
            gi = if_req_ready;
            gm = mem_req_ready;
            tick();
            if (gi) if_req_valid = 1'b0;
            if (gm) mem_req_valid = 1'b0;
            cnt++;
        end
        if (if_req_valid || mem_req_valid) begin
            fail_now("grant_timeout");
            if_req_valid = 1'b0;
            mem_req_valid = 1'b0;
        end
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 4000) begin
            tick();
            cnt++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    function automatic logic [63:0] rand_addr();
        return {32'h0, 32'h8000_0000 | ($urandom & 32'h00FF_FFF8)};
    endfunction

    function automatic logic [7:0] pick_len();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'd7;
            default: return 8'($urandom_range(0, 5));
        endcase
    endfunction

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [63:0] ma;
        int          cnt;
        int          sel;
        reset_n = 1'b0;
        if_req_valid = 1'b0; if_addr = '0; if_len = '0; if_size = '0;
        mem_req_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = '0; mem_size = '0; mem_wdata = '0;
        repeat (3) tick();

        chk("rst_ar_valid", 64'(bus_ar_valid), 64'd0);
        chk("rst_aw_valid", 64'(bus_aw_valid), 64'd0);
        chk("rst_addr", bus_addr, 64'd0);
        chk("rst_len", 64'(bus_len), 64'd0);
        chk("rst_size", 64'(bus_size), 64'd0);
        chk("rst_data", bus_data, 64'd0);
        chk("rst_ready", 64'({if_req_ready, mem_req_ready}), 64'd0);
        chk("rst_rvalid", 64'({if_r_valid, mem_r_valid, mem_w_done}), 64'd0);
        reset_n = 1'b1;
        tick();

        run_round(1, 0, 64'h8000_0000, 8'd0, 2'b11, 0, 64'd0, 8'd0, 2'b00, 64'd0);
        run_round(1, 1, 64'h8000_0040, 8'd1, 2'b11, 0, 64'h8000_0100, 8'd3, 2'b11, 64'd0);
        run_round(0, 1, 64'd0, 8'd0, 2'b00, 1, 64'h8000_1000, 8'd5, 2'b10, 64'hDEAD_BEEF);
        run_round(0, 1, 64'd0, 8'd0, 2'b00, 0, 64'h8000_2000, 8'd7, 2'b11, 64'd0);
        for (int r = 0; r < 6; r++)
            run_round(1, 1, rand_addr(), pick_len(), 2'b11, 1'($urandom_range(0, 1)),
                      rand_addr(), pick_len(), 2'($urandom_range(0, 3)), {$urandom, $urandom});
        for (int r = 0; r < 30; r++) begin
            sel = int'($urandom_range(0, 3));
            run_round(sel != 1, sel != 0, rand_addr(), pick_len(), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), rand_addr(), pick_len(), 2'($urandom_range(0, 3)),
                      {$urandom, $urandom});
        end

        // Asynchronous reset during beat 2 of an 8-beat burst; the stub is driven by hand here.
        manual_bus = 1'b1;
        ma = 64'h8000_3000;
        exp_q.push_back('{EV_GRANT, 1'b1, 64'd0, 2'b00});
        for (int b = 0; b < 2; b++) exp_q.push_back('{EV_BEAT, 1'b1, data_fn(ma, b), resp_fn(ma, b)});
        mem_addr = ma; mem_len = 8'd7; mem_we = 1'b0; mem_size = 2'b11; mem_req_valid = 1'b1;
        cnt = 0;
        while (mem_req_valid && cnt < 100) begin
            @(negedge clk);
            if (mem_req_ready) begin
                tick();
                mem_req_valid = 1'b0;
            end else begin
                tick();
            end
            cnt++;
        end
        if (mem_req_valid) begin
            fail_now("rst_test_grant_timeout");
            mem_req_valid = 1'b0;
        end
        chk("rst_test_ar_valid", 64'(bus_ar_valid), 64'd1);
        bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus_r_valid = 1'b1; bus_r_data = data_fn(ma, b); bus_resp = resp_fn(ma, b);
            tick();
            bus_r_valid = 1'b0; bus_resp = '0;
        end
        bus_r_valid = 1'b1; bus_r_data = data_fn(ma, 2); bus_resp = 2'b10;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_mem_r_valid", 64'(mem_r_valid), 64'd0);
        chk("mid_rst_mem_r_data", mem_r_data, 64'd0);
        chk("mid_rst_mem_resp", 64'(mem_resp), 64'd0);
        chk("mid_rst_if_r_valid", 64'(if_r_valid), 64'd0);
        chk("mid_rst_ar_valid", 64'(bus_ar_valid), 64'd0);
        chk("mid_rst_addr", bus_addr, 64'd0);
        chk("mid_rst_len", 64'(bus_len), 64'd0);
        chk("mid_rst_pending_events", 64'(exp_q.size()), 64'd0);
        bus_r_valid = 1'b0; bus_r_data = '0; bus_resp = '0;
        tick();
        tick();
        reset_n = 1'b1;
        manual_bus = 1'b0;
        exp_q.delete();
        bus_q.delete();
`ifdef YSYX_22041071_ARB_RR_EN
        last_grant_m = 1'b0;
`endif
        tick();
        run_round(1, 1, 64'h8000_4000, 8'd2, 2'b11, 0, 64'h8000_5000, 8'd0, 2'b11, 64'd0);
        chk("bus_queue_empty", 64'(bus_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
